// File: rtl/jellyvl_synctimer_pkg.sv
// Shared synctimer types: controller state encoding and the timer/time-sample word.
package jellyvl_synctimer_pkg;

    localparam int SYNCTIMER_TIMER_WIDTH = 64;

    typedef logic [SYNCTIMER_TIMER_WIDTH-1:0] t_time;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RENEW   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_TRACK   = 2'd3
    } t_state;

endpackage

// File: rtl/jellyvl_synctimer_renewer_timeout.sv
// Saturating sample-loss watchdog: counts cycles since the last sample and pulses expire once
// when the count reaches param_timeout (param_timeout of 0 disables it).
module jellyvl_synctimer_renewer_timeout
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = 32
)(
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     clear,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    output logic                     expire
);

    logic [TIMEOUT_WIDTH-1:0] count_reg;

    // A sample in the expiry cycle wins, so clear masks the pulse.
    assign expire = !clear
                 && (param_timeout != '0)
                 && (count_reg == param_timeout - TIMEOUT_WIDTH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_reg != '1) begin
            count_reg <= count_reg + TIMEOUT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/jellyvl_synctimer_renewer.sv
// Turns captured master-time samples into latency-compensated corrections (renew or slew).
// Optional statistics outputs are enabled by defining JELLYVL_SYNCTIMER_RENEWER_STATS_EN.
module jellyvl_synctimer_renewer
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH   = SYNCTIMER_TIMER_WIDTH,
    parameter int LATENCY_WIDTH = 24,
    parameter int HOLDOFF_WIDTH = 8,
    parameter int TIMEOUT_WIDTH = 32
)(
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     enable,
    input  logic [LATENCY_WIDTH-1:0] param_latency,
    input  logic [HOLDOFF_WIDTH-1:0] param_holdoff,
    input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
    input  logic [TIMER_WIDTH-1:0]   sample_time,
    input  logic                     sample_valid,
    input  logic                     request_renew,
    output logic [TIMER_WIDTH-1:0]   correct_time,
    output logic                     correct_renew,
    output logic                     correct_valid,
    output logic                     sync_lost
`ifdef JELLYVL_SYNCTIMER_RENEWER_STATS_EN
    ,
    output logic [31:0]              stat_renew_count,
    output logic [31:0]              stat_sample_count,
    output logic [15:0]              stat_lost_count
`endif
);

    t_state                   state_reg, state_next;
    logic [HOLDOFF_WIDTH-1:0] holdoff_reg, holdoff_next;
    logic                     emit, emit_renew;
    logic                     expire;
    logic [TIMER_WIDTH-1:0]   comp_time;

    assign comp_time = sample_time + TIMER_WIDTH'(param_latency);

    jellyvl_synctimer_renewer_timeout #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .reset         (reset),
        .clk           (clk),
        .clear         (sample_valid),
        .param_timeout (param_timeout),
        .expire        (expire)
    );

    always_comb begin
        state_next   = state_reg;
        holdoff_next = holdoff_reg;
        emit         = 1'b0;
        emit_renew   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RENEW;
                end
            end
            ST_RENEW: begin
                if (sample_valid) begin
                    emit         = 1'b1;
                    emit_renew   = 1'b1;
                    holdoff_next = param_holdoff;
                    state_next   = (param_holdoff != '0) ? ST_HOLDOFF : ST_TRACK;
                end
            end
            ST_HOLDOFF: begin
                // request_renew is ignored here; the sample reaching zero is dropped too.
                if (sample_valid) begin
                    if (holdoff_reg <= HOLDOFF_WIDTH'(1)) begin
                        holdoff_next = '0;
                        state_next   = ST_TRACK;
                    end else begin
                        holdoff_next = holdoff_reg - HOLDOFF_WIDTH'(1);
                    end
                end
            end
            ST_TRACK: begin
                if (sample_valid) begin
                    emit       = 1'b1;
                    emit_renew = request_renew;
                    if (request_renew) begin
                        holdoff_next = param_holdoff;
                        state_next   = (param_holdoff != '0) ? ST_HOLDOFF : ST_TRACK;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Disable and sample loss override whatever the active state decided.
        if (state_reg != ST_IDLE) begin
            if (!enable) begin
                state_next   = ST_IDLE;
                holdoff_next = '0;
                emit         = 1'b0;
                emit_renew   = 1'b0;
            end else if (expire) begin
                state_next   = ST_RENEW;
                holdoff_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            holdoff_reg   <= '0;
            correct_time  <= '0;
            correct_renew <= 1'b0;
            correct_valid <= 1'b0;
            sync_lost     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            holdoff_reg   <= holdoff_next;
            correct_valid <= emit;
            if (emit) begin
                correct_time  <= comp_time;
                correct_renew <= emit_renew;
            end
            if (sample_valid) begin
                sync_lost <= 1'b0;
            end else if (expire) begin
                sync_lost <= 1'b1;
            end
        end
    end

`ifdef JELLYVL_SYNCTIMER_RENEWER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_renew_count  <= '0;
            stat_sample_count <= '0;
            stat_lost_count   <= '0;
        end else begin
            if (emit && emit_renew) begin
                stat_renew_count <= stat_renew_count + 32'd1;
            end
            if (sample_valid) begin
                stat_sample_count <= stat_sample_count + 32'd1;
            end
            if (expire) begin
                stat_lost_count <= stat_lost_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jellyvl_synctimer_renewer.sv
// Scoreboard bench for jellyvl_synctimer_renewer: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the correction rules.
module tb_jellyvl_synctimer_renewer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] param_latency = '0;
    logic [7:0]  param_holdoff = '0;
    logic [31:0] param_timeout = '0;
    logic [63:0] sample_time = '0;
    logic        sample_valid = 1'b0;
    logic        request_renew = 1'b0;
    logic [63:0] correct_time;
    logic        correct_renew;
    logic        correct_valid;
    logic        sync_lost;

    jellyvl_synctimer_renewer dut (
        .reset         (reset),
        .clk           (clk),
        .enable        (enable),
        .param_latency (param_latency),
        .param_holdoff (param_holdoff),
        .param_timeout (param_timeout),
        .sample_time   (sample_time),
        .sample_valid  (sample_valid),
        .request_renew (request_renew),
        .correct_time  (correct_time),
        .correct_renew (correct_renew),
        .correct_valid (correct_valid),
        .sync_lost     (sync_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] t;
        logic        r;
    } exp_t;

    exp_t exp_q[$];
    logic lost_q[$];
    int   total = 0;
    int   bad = 0;
    bit   checking = 1'b0;

    // Behavioural model: "active" means corrections may be issued, "need_renew" means the next
    // accepted sample must overwrite, drop_left counts samples still to be discarded.
    bit     m_active;
    bit     m_need_renew;
    int     m_drop_left;
    longint m_quiet;
    bit     m_lost;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_active     = 1'b0;
        m_need_renew = 1'b1;
        m_drop_left  = 0;
        m_quiet      = 0;
        m_lost       = 1'b0;
    endtask

    // Drive one cycle of inputs (called at a falling edge) and predict its effect.
    task automatic apply(input logic en, input logic sv, input logic [63:0] st, input logic rr);
        exp_t e;
        enable        = en;
        sample_valid  = sv;
        sample_time   = st;
        request_renew = rr;
        e.t = st + 64'(param_latency);
        if (!m_active) begin
            if (en) begin
                m_active     = 1'b1;
                m_need_renew = 1'b1;
                m_drop_left  = 0;
            end
        end else if (!en) begin
            m_active = 1'b0;
        end else if (sv) begin
            if (m_need_renew) begin
                e.r = 1'b1;
                exp_q.push_back(e);
                m_need_renew = 1'b0;
                m_drop_left  = int'(param_holdoff);
            end else if (m_drop_left > 0) begin
                m_drop_left--;
            end else begin
                e.r = rr;
                exp_q.push_back(e);
                if (rr) m_drop_left = int'(param_holdoff);
            end
        end
        if (sv) begin
            m_quiet = 0;
            m_lost  = 1'b0;
        end else begin
            m_quiet++;
            if (param_timeout != 0 && m_quiet == longint'(param_timeout)) begin
                m_lost       = 1'b1;
                m_need_renew = 1'b1;
                m_drop_left  = 0;
            end
        end
        lost_q.push_back(m_lost);
    endtask

    task automatic step(input logic en, input logic sv, input logic [63:0] st, input logic rr);
        @(negedge clk);
        apply(en, sv, st, rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_time"},  correct_time, 64'd0);
        check({tag, "_renew"}, 64'(correct_renew), 64'd0);
        check({tag, "_valid"}, 64'(correct_valid), 64'd0);
        check({tag, "_lost"},  64'(sync_lost), 64'd0);
    endtask

    // Monitor: pops an expected correction whenever the DUT presents one, and the lost flag each cycle.
    initial begin
        exp_t e;
        logic l;
        forever begin
            @(posedge clk);
            #1;
            if (checking) begin
                if (correct_valid) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_valid: got time %0h renew %0b expected no output", correct_time, correct_renew);
                    end else begin
                        e = exp_q.pop_front();
                        $display("correction time=%0h renew=%0b", correct_time, correct_renew);
                        check("correct_time", correct_time, e.t);
                        check("correct_renew", 64'(correct_renew), 64'(e.r));
                    end
                end
                if (lost_q.size() != 0) begin
                    l = lost_q.pop_front();
                    check("sync_lost", 64'(sync_lost), 64'(l));
                end
            end
        end
    end

    initial begin
        model_reset();
        param_latency = 24'd100;
        param_holdoff = 8'd3;
        param_timeout = 32'd0;
        #1 reset = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checking = 1'b1;
        apply(1'b1, 1'b0, 64'd0, 1'b0);

        // First sample after enable: renew with latency added.
        step(1'b1, 1'b1, 64'd1000, 1'b0);
        idle(2);
        // Holdoff of 3: three samples dropped, fourth emitted as slew.
        step(1'b1, 1'b1, 64'd2000, 1'b0);
        step(1'b1, 1'b1, 64'd3000, 1'b1);
        idle(1);
        step(1'b1, 1'b1, 64'd4000, 1'b0);
        step(1'b1, 1'b1, 64'd4500, 1'b0);
        idle(1);
        // Tracking renew request reloads holdoff.
        step(1'b1, 1'b1, 64'd5000, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 64'd5100 + 64'(i * 10), 1'b0);
        // Wrap-around of the compensated time.
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFCE, 1'b0);
        idle(1);

        // Sample loss after 10 quiet cycles, recovery with a renew.
        param_timeout = 32'd10;
        step(1'b1, 1'b1, 64'd6000, 1'b0);
        idle(10);
        check("lost_model_expect", 64'(m_lost), 64'd1);
        idle(2);
        step(1'b1, 1'b1, 64'd7000, 1'b0);
        idle(2);

        // Randomized traffic.
        param_timeout = 32'd7;
        for (int i = 0; i < 600; i++) begin
            logic en, sv, rr;
            if (i % 60 == 0) begin
                param_holdoff = 8'($urandom_range(0, 3));
                param_latency = 24'($urandom);
            end
            en = ($urandom_range(0, 49) != 0);
            sv = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 3) == 0);
            step(en, sv, {32'($urandom), 32'($urandom)}, rr);
        end

        // Asynchronous reset while in holdoff.
        param_timeout = 32'd0;
        param_holdoff = 8'd3;
        param_latency = 24'd100;
        step(1'b0, 1'b0, 64'd0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 64'd9000, 1'b0);
        step(1'b1, 1'b1, 64'd9100, 1'b0);
        step(1'b1, 1'b0, 64'd0, 1'b0);
        #2;
        checking = 1'b0;
        reset = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        enable = 1'b0;
        sample_valid = 1'b0;
        request_renew = 1'b0;
        exp_q.delete();
        lost_q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        checking = 1'b1;
        apply(1'b1, 1'b0, 64'd0, 1'b0);
        step(1'b1, 1'b1, 64'd12345, 1'b0);
        idle(3);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
